// File: rtl/mem16_8_if.sv
// mem16_8_if: bus bundle between the mem16_8 unpacker, the SRAM read port
// and the byte-wide consumer.
//
//   sram_addr  [AW-1:0]  SRAM read word address       (unpacker -> SRAM)
//   sram_ren             SRAM read enable             (unpacker -> SRAM)
//   sram_rdata [DW-1:0]  SRAM read data, 1-cycle lat. (SRAM -> unpacker)
//   r_data     [7:0]     output byte                  (unpacker -> consumer)
//   r_valid              r_data valid                 (unpacker -> consumer)
//   r_ready              consumer accepts byte        (consumer -> unpacker)
//   icounter   [2:0]     row of the byte on r_data    (unpacker -> consumer)
//   jcounter   [2:0]     column of the byte on r_data (unpacker -> consumer)
//
// Modport master is the unpacker side; slave is the SRAM/consumer side.
`timescale 1ns/1ps
interface mem16_8_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic [AW-1:0] sram_addr;
    logic          sram_ren;
    logic [DW-1:0] sram_rdata;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ready;
    logic [2:0]    icounter;
    logic [2:0]    jcounter;

    modport master (
        output sram_addr, sram_ren,
        input  sram_rdata,
        output r_data, r_valid, icounter, jcounter,
        input  r_ready
    );

    modport slave (
        input  sram_addr, sram_ren,
        output sram_rdata,
        input  r_data, r_valid, icounter, jcounter,
        output r_ready
    );
endinterface

// File: rtl/mem16_8.sv
// mem16_8: SRAM read-back unpacker.
//
// On start (accepted only in IDLE) it burst-reads 32 consecutive 16-bit words
// starting at base_addr (address wraps modulo 2^AW) into a 64-byte buffer,
// then streams the 8x8 block out one byte per valid/ready handshake, tagged
// with its (i, j) position. The high byte of word k is buffer byte 2k and the
// low byte is byte 2k+1. Byte index is b = i*8 + j.
//
// Ports:
//   clock      rising-edge system clock
//   reset      synchronous, active-high
//   start      begin a block transfer (sampled only in IDLE)
//   base_addr  SRAM word address of word 0, latched when start is accepted
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last byte is accepted
//   bus        mem16_8_if.master: SRAM read port and byte stream
//
// Build option: define MEM16_8_TRANSPOSE_EN for column-major emission
// (i fastest). Default build emits row-major (j fastest). Fetch timing is the
// same in both builds.
`timescale 1ns/1ps
module mem16_8 #(
    parameter int AW = 18,
    parameter int DW = 16   // must be 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    mem16_8_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] sram_addr_q;
    logic          sram_ren_q;
    logic [4:0]    k_q;          // word index currently on the SRAM address bus
    logic          rd_valid_q;   // sram_rdata carries a word this cycle
    logic [4:0]    rd_idx_q;     // which word that is
    logic [7:0]    r_data_q;
    logic          r_valid_q;
    logic [2:0]    i_q, j_q;
    logic [2:0]    i_next, j_next;
    logic          xfer;
    logic          last_byte;
    logic [DW-1:0] rdata_w;

    logic [7:0]    byte_buf [0:63];

    assign rdata_w   = bus.sram_rdata;
    assign xfer      = r_valid_q && bus.r_ready;
    // (7,7) is the final position in both emission orders.
    assign last_byte = (i_q == 3'd7) && (j_q == 3'd7);

    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_ren  = sram_ren_q;
    assign bus.r_data    = r_data_q;
    assign bus.r_valid   = r_valid_q;
    assign bus.icounter  = i_q;
    assign bus.jcounter  = j_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and next emission position.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        i_next     = i_q;
        j_next     = j_q;

`ifdef MEM16_8_TRANSPOSE_EN
        i_next = i_q + 3'd1;
        if (i_q == 3'd7) j_next = j_q + 3'd1;
`else
        j_next = j_q + 3'd1;
        if (j_q == 3'd7) i_next = i_q + 3'd1;
`endif

        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: if (k_q == 5'd31) state_next = S_DRAIN;
            S_DRAIN: state_next = S_EMIT;
            S_EMIT:  if (xfer && last_byte) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_addr_q <= '0;
            sram_ren_q  <= 1'b0;
            k_q         <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Read data returns one cycle after the enable the SRAM saw, so
            // the capture strobe is the enable delayed by one register.
            rd_valid_q <= sram_ren_q;
            rd_idx_q   <= k_q;
            done       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        // The address register doubles as the latched base.
                        sram_addr_q <= base_addr;
                        sram_ren_q  <= 1'b1;
                        k_q         <= '0;
                        busy        <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (k_q == 5'd31) begin
                        sram_ren_q  <= 1'b0;
                        sram_addr_q <= '0;
                    end else begin
                        k_q         <= k_q + 5'd1;
                        sram_addr_q <= sram_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    // Byte 0 was captured long ago; word 31 lands this edge.
                    r_valid_q <= 1'b1;
                    r_data_q  <= byte_buf[0];
                    i_q       <= '0;
                    j_q       <= '0;
                end
                S_EMIT: begin
                    if (xfer) begin
                        if (last_byte) begin
                            r_valid_q <= 1'b0;
                            r_data_q  <= '0;
                            i_q       <= '0;
                            j_q       <= '0;
                            done      <= 1'b1;
                        end else begin
                            r_data_q <= byte_buf[{i_next, j_next}];
                            i_q      <= i_next;
                            j_q      <= j_next;
                        end
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Block buffer.
    // NOTE: the buffer has no reset; its contents are always rewritten by a
    // fetch before they are read, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clock) begin
        if (rd_valid_q) begin
            byte_buf[{rd_idx_q, 1'b0}] <= rdata_w[15:8];
            byte_buf[{rd_idx_q, 1'b1}] <= rdata_w[7:0];
        end
    end

endmodule

// File: tb/tb_mem16_8.sv
// tb_mem16_8: self-checking bench for mem16_8 with an SRAM model and a
// block-level reference (expected reads, byte order, done/busy timing).
`timescale 1ns/1ps
module tb_mem16_8;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] sram_mem [bit [17:0]];

    mem16_8_if #(.AW(AW), .DW(DW)) bus ();

    mem16_8 #(.AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    // SRAM: data valid one cycle after the enable is sampled.
    always @(posedge clock) begin
        if (bus.sram_ren)
            bus.sram_rdata <= sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : 16'hDEAD;
    end

    task automatic fill_counting(input logic [17:0] base);
        for (int k = 0; k < 32; k++) begin
            logic [17:0] a;
            logic [7:0]  hi, lo;
            a  = base + 18'(k);
            hi = 8'(2 * k);
            lo = 8'(2 * k + 1);
            sram_mem[a] = {hi, lo};
        end
    endtask

    task automatic fill_random(input logic [17:0] base);
        for (int k = 0; k < 32; k++) begin
            logic [17:0] a;
            a = base + 18'(k);
            sram_mem[a] = 16'($urandom);
        end
    endtask

    // Runs one block from start. ready_mode: 0 always ready, 1 alternating
    // starting ready on the first emit cycle, 2 random. reset_at > 0 asserts
    // reset on that cycle and checks the cleared outputs. poke_start pulses
    // start during FETCH and during DONE. exp_done_cycle > 0 checks the done
    // cycle against an absolute expectation.
    task automatic run_block(input logic [17:0] base, input int ready_mode,
                             input int reset_at, input bit poke_start,
                             input int exp_done_cycle);
        logic [7:0] bytes [64];
        int         oi [64];
        int         oj [64];
        int         pos;
        int         last_xfer;
        bit         finished;
        bit         rdy;
        bit         exp_ren, exp_valid, exp_done, exp_busy;
        logic [17:0] ea;

        for (int k = 0; k < 32; k++) begin
            logic [15:0] w;
            ea = base + 18'(k);
            w  = sram_mem[ea];
            bytes[2*k]   = w[15:8];
            bytes[2*k+1] = w[7:0];
        end
        for (int n = 0; n < 64; n++) begin
`ifdef MEM16_8_TRANSPOSE_EN
            oi[n] = n % 8; oj[n] = n / 8;
`else
            oi[n] = n / 8; oj[n] = n % 8;
`endif
        end

        @(negedge clock);
        start     = 1'b1;
        base_addr = base;
        @(posedge clock);           // cycle 0: start sampled in IDLE

        pos = 0; last_xfer = -1; finished = 1'b0;
        for (int n = 1; n <= 600 && !finished; n++) begin
            @(negedge clock);

            exp_ren = (n >= 1) && (n <= 32);
            vectors++;
            if (bus.sram_ren !== exp_ren) begin
                miscompares++;
                $display("FAIL sram_ren cycle %0d: got %b want %b", n, bus.sram_ren, exp_ren);
            end
            if (exp_ren) begin
                ea = base + 18'(n - 1);
                vectors++;
                if (bus.sram_addr !== ea) begin
                    miscompares++;
                    $display("FAIL sram_addr cycle %0d: got %h want %h", n, bus.sram_addr, ea);
                end
            end

            exp_valid = (n >= 34) && (pos < 64);
            vectors++;
            if (bus.r_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL r_valid cycle %0d: got %b want %b", n, bus.r_valid, exp_valid);
            end
            if (exp_valid) begin
                logic [7:0] eb;
                logic [2:0] ei, ej;
                ei = 3'(oi[pos]);
                ej = 3'(oj[pos]);
                eb = bytes[oi[pos] * 8 + oj[pos]];
                vectors++;
                if ({bus.r_data, bus.icounter, bus.jcounter} !== {eb, ei, ej}) begin
                    miscompares++;
                    $display("FAIL byte %0d cycle %0d: got %h@(%0d,%0d) want %h@(%0d,%0d)",
                             pos, n, bus.r_data, bus.icounter, bus.jcounter, eb, ei, ej);
                end
            end

            exp_done = (last_xfer >= 0) && (n == last_xfer + 1);
            exp_busy = (last_xfer < 0) || (n <= last_xfer + 1);
            vectors++;
            if ({done, busy} !== {exp_done, exp_busy}) begin
                miscompares++;
                $display("FAIL done/busy cycle %0d: got %b/%b want %b/%b",
                         n, done, busy, exp_done, exp_busy);
            end

            if (n == reset_at) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clock);
                vectors++;
                if ({bus.sram_addr, bus.sram_ren, bus.r_data, bus.r_valid,
                     bus.icounter, bus.jcounter, busy, done} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_clear: got addr=%h ren=%b data=%h valid=%b i=%0d j=%0d busy=%b done=%b want all 0",
                             bus.sram_addr, bus.sram_ren, bus.r_data, bus.r_valid,
                             bus.icounter, bus.jcounter, busy, done);
                end
                reset = 1'b0;
                return;
            end

            if (last_xfer >= 0 && n == last_xfer + 3) finished = 1'b1;

            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.r_ready = rdy;
            if (exp_valid && rdy) begin
                pos++;
                if (pos == 64) last_xfer = n;
            end
            start     = poke_start && ((n == 10) || exp_done);
            base_addr = 18'($urandom);   // must be ignored after acceptance
        end
        start = 1'b0;

        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL block_timeout: %0d of 64 bytes transferred, want 64 within 600 cycles", pos);
        end
        if (exp_done_cycle > 0) begin
            vectors++;
            if (last_xfer + 1 != exp_done_cycle) begin
                miscompares++;
                $display("FAIL done_cycle: got %0d want %0d", last_xfer + 1, exp_done_cycle);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({bus.sram_addr, bus.sram_ren, bus.r_data, bus.r_valid,
             bus.icounter, bus.jcounter, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got addr=%h ren=%b data=%h valid=%b i=%0d j=%0d busy=%b done=%b want all 0",
                     bus.sram_addr, bus.sram_ren, bus.r_data, bus.r_valid,
                     bus.icounter, bus.jcounter, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        fill_counting(18'h00100);
        run_block(18'h00100, 0, 0, 1'b0, 98);
    endtask

    task automatic test_backpressure();
        fill_counting(18'h00100);
        run_block(18'h00100, 1, 0, 1'b0, 98 + 63);
    endtask

    task automatic test_addr_wrap();
        fill_random(18'h3FFF0);
        run_block(18'h3FFF0, 0, 0, 1'b0, 98);
    endtask

    task automatic test_start_ignored();
        fill_random(18'h01234);
        run_block(18'h01234, 0, 0, 1'b1, 98);
    endtask

    task automatic test_reset_midop();
        fill_random(18'h20000);
        run_block(18'h20000, 0, 50, 1'b0, 0);
        fill_counting(18'h00100);
        run_block(18'h00100, 0, 0, 1'b0, 98);
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            logic [17:0] b;
            b = 18'($urandom);
            fill_random(b);
            run_block(b, 2, 0, 1'b0, 0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        bus.r_ready = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_addr_wrap();
        test_start_ignored();
        test_reset_midop();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
